// File: rtl/booth_digit_sequencer.sv
// booth_digit_sequencer
//   Feeds the Booth-encoded dynamic-alignment MAC/accumulator. Each accepted
//   (activation, weight) request is split into radix-4 Booth windows, LSB
//   first, one per cycle, while the activation is held steady. The block also
//   produces the accumulator controls: enable, clear, end-of-product (nep) and
//   the save-slot index (ep_count). At a neuron boundary it waits out the
//   accumulator pipeline before it pulses done.
//
//   Optional feature macro: REG_OUT_EN
//     When defined, pe_in, w_win, sign_ex_en, pe_ena, acc_clear, nep, ep_count
//     and done pass through one extra register stage, so they arrive one cycle
//     later. in_ready, busy and ep_ovf keep their timing.
//
//   Ports
//     clk, rst       clock; asynchronous active-low reset
//     in_valid/ready request handshake
//     in_act         4-bit activation
//     in_wgt         WGT_W-bit signed weight
//     in_last        request is the final product of the neuron
//     in_sext        activation is signed
//     pe_in          activation sent to the MAC
//     w_win          Booth window {b(2k+1), b(2k), b(2k-1)}
//     sign_ex_en     latched in_sext
//     pe_ena         MAC/accumulator enable
//     acc_clear      accumulator clear pulse
//     nep            high on the final digit of each product
//     ep_count       save-slot index of the current product
//     busy           sequencer not idle
//     done           one-cycle pulse when a neuron completes
//     ep_ovf         sticky: a product was issued beyond EP_MAX
module booth_digit_sequencer #(
  parameter int unsigned WGT_W     = 8,
  parameter int unsigned EP_MAX    = 8,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_act,
  input  logic [WGT_W-1:0] in_wgt,
  input  logic             in_last,
  input  logic             in_sext,
  output logic [3:0]       pe_in,
  output logic [2:0]       w_win,
  output logic             sign_ex_en,
  output logic             pe_ena,
  output logic             acc_clear,
  output logic             nep,
  output logic [3:0]       ep_count,
  output logic             busy,
  output logic             done,
  output logic             ep_ovf
);

  localparam int unsigned ND  = WGT_W / 2;
  localparam int unsigned KW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned FW  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int unsigned EPW = 4;

  localparam logic [KW-1:0]  K_LAST = KW'(ND - 1);
  localparam logic [FW-1:0]  F_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [EPW-1:0] EP_TOP = EPW'(EP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  // Booth window k of w, with an implicit zero below bit 0.
  function automatic logic [2:0] booth_win(input logic [WGT_W-1:0] w,
                                           input logic [KW-1:0]    k);
    logic [WGT_W:0] ext;
    ext = {w, 1'b0};
    return 3'(ext >> {k, 1'b0});
  endfunction

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [FW-1:0]    fl_q, fl_d;
  logic [3:0]       act_q, act_d;
  logic [WGT_W-1:0] wgt_q, wgt_d;
  logic             last_q, last_d;
  logic             sext_q, sext_d;
  logic             first_q, first_d;
  logic [EPW-1:0]   ep_q, ep_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  logic             in_ready_q, in_ready_d;
  logic [2:0]       win_q, win_d;
  logic             pe_ena_q, pe_ena_d;
  logic             acc_clear_q, acc_clear_d;
  logic             nep_q, nep_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             take;

  assign accept = in_valid && in_ready_q;

  // Next state, request latch and slot bookkeeping.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fl_d    = fl_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    last_d  = last_q;
    sext_d  = sext_q;
    first_d = first_q;
    ep_d    = ep_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          take    = 1'b1;
          first_d = 1'b0;
          k_d     = '0;
          // Slot index already pinned at the top: this product overflows.
          if (full_q) ovf_d = 1'b1;
          state_d = first_q ? S_CLR : S_RUN;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          if (last_q) begin
            state_d = S_FLUSH;
            fl_d    = '0;
          end else begin
            if (ep_q == EP_TOP) full_d = 1'b1;
            else                ep_d   = ep_q + EPW'(1);
            if (accept) begin
              // Back-to-back product: restart the digit counter, no bubble.
              take = 1'b1;
              k_d  = '0;
              if (ep_q == EP_TOP) ovf_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_FLUSH: begin
        if (fl_q == F_LAST) begin
          state_d = S_DONE;
          ep_d    = '0;
          full_d  = 1'b0;
          first_d = 1'b1;
        end else begin
          fl_d = fl_q + FW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take) begin
      act_d  = in_act;
      wgt_d  = in_wgt;
      last_d = in_last;
      sext_d = in_sext;
    end
  end

  // Registered outputs decoded from the next state so they line up with it.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE) ||
                  ((state_d == S_RUN) && (k_d == K_LAST) && !last_d);
    pe_ena_d    = (state_d == S_RUN) || (state_d == S_FLUSH);
    acc_clear_d = (state_d == S_CLR);
    nep_d       = (state_d == S_RUN) && (k_d == K_LAST);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    win_d       = win_q;
    if (state_d == S_RUN)       win_d = booth_win(wgt_d, k_d);
    else if (state_d != S_IDLE) win_d = 3'b000;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      fl_q        <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      last_q      <= 1'b0;
      sext_q      <= 1'b0;
      first_q     <= 1'b1;
      ep_q        <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      win_q       <= '0;
      pe_ena_q    <= 1'b0;
      acc_clear_q <= 1'b0;
      nep_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fl_q        <= fl_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      last_q      <= last_d;
      sext_q      <= sext_d;
      first_q     <= first_d;
      ep_q        <= ep_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      win_q       <= win_d;
      pe_ena_q    <= pe_ena_d;
      acc_clear_q <= acc_clear_d;
      nep_q       <= nep_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign ep_ovf   = ovf_q;

`ifdef REG_OUT_EN
  logic [3:0] pe_in_o_q;
  logic [2:0] w_win_o_q;
  logic       sext_o_q;
  logic       pe_ena_o_q;
  logic       acc_clear_o_q;
  logic       nep_o_q;
  logic [3:0] ep_o_q;
  logic       done_o_q;

  // Extra retiming stage on everything the accumulator sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_in_o_q     <= '0;
      w_win_o_q     <= '0;
      sext_o_q      <= 1'b0;
      pe_ena_o_q    <= 1'b0;
      acc_clear_o_q <= 1'b0;
      nep_o_q       <= 1'b0;
      ep_o_q        <= '0;
      done_o_q      <= 1'b0;
    end else begin
      pe_in_o_q     <= act_q;
      w_win_o_q     <= win_q;
      sext_o_q      <= sext_q;
      pe_ena_o_q    <= pe_ena_q;
      acc_clear_o_q <= acc_clear_q;
      nep_o_q       <= nep_q;
      ep_o_q        <= ep_q;
      done_o_q      <= done_q;
    end
  end

  assign pe_in      = pe_in_o_q;
  assign w_win      = w_win_o_q;
  assign sign_ex_en = sext_o_q;
  assign pe_ena     = pe_ena_o_q;
  assign acc_clear  = acc_clear_o_q;
  assign nep        = nep_o_q;
  assign ep_count   = ep_o_q;
  assign done       = done_o_q;
`else
  assign pe_in      = act_q;
  assign w_win      = win_q;
  assign sign_ex_en = sext_q;
  assign pe_ena     = pe_ena_q;
  assign acc_clear  = acc_clear_q;
  assign nep        = nep_q;
  assign ep_count   = ep_q;
  assign done       = done_q;
`endif

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// Directed bench for booth_digit_sequencer (WGT_W=8, EP_MAX=8, FLUSH_CYC=2).
module tb_booth_digit_sequencer;

`ifdef REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_act = '0;
  logic [7:0] in_wgt = '0;
  logic       in_last = 1'b0;
  logic       in_sext = 1'b0;
  logic [3:0] pe_in;
  logic [2:0] w_win;
  logic       sign_ex_en;
  logic       pe_ena;
  logic       acc_clear;
  logic       nep;
  logic [3:0] ep_count;
  logic       busy;
  logic       done;
  logic       ep_ovf;

  int errors = 0;
  int checks = 0;

  booth_digit_sequencer #(.WGT_W(8), .EP_MAX(8), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last), .in_sext(in_sext),
    .pe_in(pe_in), .w_win(w_win), .sign_ex_en(sign_ex_en),
    .pe_ena(pe_ena), .acc_clear(acc_clear), .nep(nep),
    .ep_count(ep_count), .busy(busy), .done(done), .ep_ovf(ep_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pe_ena, acc_clear, nep, w_win, ep_count, done, pe_in, sign_ex_en}
  function automatic logic [15:0] pk(input logic ena, input logic clr, input logic nv,
                                     input logic [2:0] win, input logic [3:0] ep,
                                     input logic dn, input logic [3:0] act, input logic sx);
    return {ena, clr, nv, win, ep, dn, act, sx};
  endfunction

  function automatic logic [15:0] obs_daa();
    return {pe_ena, acc_clear, nep, w_win, ep_count, done, pe_in, sign_ex_en};
  endfunction

  logic [15:0] e1 [0:8];
  logic [15:0] e2 [0:16];
  int  p;
  int  accepts;
  bit  acc_pending;
  bit  found;

  initial begin
    // Test 1 expectations: 5A / act 3 / signed / last.
    e1[0] = pk(0, 1, 0, 3'b000, 0, 0, 4'h3, 1);
    e1[1] = pk(1, 0, 0, 3'b100, 0, 0, 4'h3, 1);
    e1[2] = pk(1, 0, 0, 3'b101, 0, 0, 4'h3, 1);
    e1[3] = pk(1, 0, 0, 3'b011, 0, 0, 4'h3, 1);
    e1[4] = pk(1, 0, 1, 3'b010, 0, 0, 4'h3, 1);
    e1[5] = pk(1, 0, 0, 3'b000, 0, 0, 4'h3, 1);
    e1[6] = pk(1, 0, 0, 3'b000, 0, 0, 4'h3, 1);
    e1[7] = pk(0, 0, 0, 3'b000, 0, 1, 4'h3, 1);
    e1[8] = pk(0, 0, 0, 3'b000, 0, 0, 4'h3, 1);

    // Test 2 expectations: 5A/act3, 80/act9, FF/actC(last), back-to-back.
    e2[0]  = pk(0, 1, 0, 3'b000, 0, 0, 4'h3, 0);
    e2[1]  = pk(1, 0, 0, 3'b100, 0, 0, 4'h3, 0);
    e2[2]  = pk(1, 0, 0, 3'b101, 0, 0, 4'h3, 0);
    e2[3]  = pk(1, 0, 0, 3'b011, 0, 0, 4'h3, 0);
    e2[4]  = pk(1, 0, 1, 3'b010, 0, 0, 4'h3, 0);
    e2[5]  = pk(1, 0, 0, 3'b000, 1, 0, 4'h9, 0);
    e2[6]  = pk(1, 0, 0, 3'b000, 1, 0, 4'h9, 0);
    e2[7]  = pk(1, 0, 0, 3'b000, 1, 0, 4'h9, 0);
    e2[8]  = pk(1, 0, 1, 3'b100, 1, 0, 4'h9, 0);
    e2[9]  = pk(1, 0, 0, 3'b110, 2, 0, 4'hC, 0);
    e2[10] = pk(1, 0, 0, 3'b111, 2, 0, 4'hC, 0);
    e2[11] = pk(1, 0, 0, 3'b111, 2, 0, 4'hC, 0);
    e2[12] = pk(1, 0, 1, 3'b111, 2, 0, 4'hC, 0);
    e2[13] = pk(1, 0, 0, 3'b000, 2, 0, 4'hC, 0);
    e2[14] = pk(1, 0, 0, 3'b000, 2, 0, 4'hC, 0);
    e2[15] = pk(0, 0, 0, 3'b000, 0, 1, 4'hC, 0);
    e2[16] = pk(0, 0, 0, 3'b000, 0, 0, 4'hC, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        32'({in_ready, pe_in, w_win, sign_ex_en, pe_ena, acc_clear, nep,
             ep_count, busy, done, ep_ovf}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'({in_ready, busy}), 32'b10);

    // Test 1: single product with last.
    in_valid = 1'b1; in_wgt = 8'h5A; in_act = 4'h3; in_last = 1'b1; in_sext = 1'b1;
    for (int t = 0; t <= 8 + LAT; t++) begin
      @(negedge clk);
      if (t == 0) begin
        chk("t1_busy_ready", 32'({busy, in_ready}), 32'b10);
        in_valid = 1'b0;
      end
      if (t >= LAT) chk($sformatf("t1_step%0d", t - LAT), 32'(obs_daa()), 32'(e1[t - LAT]));
    end
    chk("t1_idle", 32'({in_ready, busy}), 32'b10);

    // Test 2: three back-to-back products, valid held.
    in_valid = 1'b1; in_wgt = 8'h5A; in_act = 4'h3; in_last = 1'b0; in_sext = 1'b0;
    for (int t = 0; t <= 16 + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) chk($sformatf("t2_step%0d", t - LAT), 32'(obs_daa()), 32'(e2[t - LAT]));
      if (t == 0) begin in_wgt = 8'h80; in_act = 4'h9; end
      if (t == 4) chk("t2_ready_k3", 32'(in_ready), 32'd1);
      if (t == 5) begin in_wgt = 8'hFF; in_act = 4'hC; in_last = 1'b1; end
      if (t == 9) begin in_valid = 1'b0; in_last = 1'b0; end
    end

    // Test 3: ten products without last; slot index saturates, overflow sticks.
    in_valid = 1'b1; in_wgt = 8'h01; in_act = 4'h1; in_last = 1'b0;
    p = 0; accepts = 0; acc_pending = in_ready;
    for (int c = 0; c < 100 && p < 10; c++) begin
      @(negedge clk);
      if (acc_pending) accepts++;
      acc_pending = in_valid && in_ready;
      if (accepts == 10) in_valid = 1'b0;
      if (nep) begin
        chk($sformatf("t3_ep%0d", p), 32'(ep_count), 32'((p < 8) ? p : 8));
        chk($sformatf("t3_ovf%0d", p), 32'(ep_ovf), 32'((p >= 9 - LAT) ? 1 : 0));
        p++;
      end
    end
    chk("t3_nep_count", 32'(p), 32'd10);
    repeat (4) @(negedge clk);
    chk("t3_ovf_sticky", 32'({ep_ovf, ep_count, busy}), 32'({1'b1, 4'd8, 1'b0}));

    // Test 4: reset during the second digit.
    in_valid = 1'b1; in_wgt = 8'h5A; in_act = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_async_reset",
        32'({in_ready, pe_in, w_win, sign_ex_en, pe_ena, acc_clear, nep,
             ep_count, busy, done, ep_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_idle_ready", 32'({in_ready, busy}), 32'b10);
    in_valid = 1'b1; in_act = 4'h6; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("t4_clear_after_reset", 32'({acc_clear, pe_ena, pe_in}), 32'({1'b1, 1'b0, 4'h6}));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("t4_done_seen", 32'(found), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
